preproc_frame_sequencer: RTL and testbench
==========================================

PREPROC_FRAME_SEQUENCER -- requirements
Module: preproc_frame_sequencer

Interface
REQ-001 Parameter FRAME_W, 8, pixels per line.
REQ-002 Parameter FRAME_H, 4, lines per frame.
REQ-003 Parameter ADDR_W, 16, address width for both buffers; must satisfy FRAME_W*FRAME_H <= 2**ADDR_W.
REQ-004 Parameter TIMEOUT, 16, maximum cycles to wait for gs_valid.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low: clk input 1, rising-edge system clock; rst_n input 1, asynchronous active-low reset.
REQ-006 Data and control ports SHALL be:
- start input 1: frame start pulse.
- abort input 1: cancel the current frame.
- busy output 1: frame in progress.
- done output 1: one-cycle pulse at frame completion.
- timeout_err output 1: sticky converter-timeout flag.
- rd_en output 1: RGB buffer read strobe.
- rd_addr output ADDR_W: RGB buffer read address.
- rd_data input 24: {R,G,B}, valid 1 cycle after rd_en.
- gs_rgb output 24: pixel to the rgb2gs unit.
- gs_rgb_en output 1: rgb2gs request.
- gs_in input 8: rgb2gs result.
- gs_valid input 1: rgb2gs result valid.
- wr_en output 1: grayscale buffer write strobe.
- wr_addr output ADDR_W: grayscale buffer write address.
- wr_data output 8: grayscale pixel.

Function
REQ-007 The FSM SHALL have states IDLE, READ, LATCH, CONVERT, WRITE, DONE and SHALL hold the pixel index idx (0..FRAME_W*FRAME_H-1).
REQ-008 IDLE SHALL go to READ on start=1, clear idx to 0 and clear timeout_err; start in any other state SHALL be ignored.
REQ-009 READ SHALL assert rd_en for exactly one cycle with rd_addr=idx, then go to LATCH.
REQ-010 LATCH SHALL register rd_data into gs_rgb, set gs_rgb_en=1, clear the wait counter and go to CONVERT.
REQ-011 CONVERT SHALL hold gs_rgb and gs_rgb_en stable until gs_valid=1 is sampled. On that edge it SHALL register gs_in into wr_data, drop gs_rgb_en and go to WRITE.
REQ-012 WRITE SHALL assert wr_en for exactly one cycle with wr_addr=idx. If idx=FRAME_W*FRAME_H-1 it SHALL go to DONE; otherwise it SHALL increment idx and go to READ.
REQ-013 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-014 Per-pixel latency SHALL be 4 cycles plus the converter latency L, where L is the cycles from gs_rgb_en rising to gs_valid sampled.
REQ-015 busy SHALL be 1 in every state except IDLE and DONE.
REQ-016 If CONVERT waits TIMEOUT cycles without gs_valid, the FSM SHALL set timeout_err=1, drop gs_rgb_en and go to IDLE without pulsing done.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE on the next edge. No done pulse SHALL be issued, and rd_en, gs_rgb_en and wr_en SHALL be 0 from that edge.
REQ-018 abort SHALL take priority over gs_valid, timeout and idx wrap in the same cycle.
REQ-019 Simultaneous start and abort in IDLE SHALL leave the FSM in IDLE.
REQ-020 gs_valid outside CONVERT SHALL be ignored.
REQ-021 rd_en and wr_en SHALL never be asserted in the same cycle.
REQ-022 idx SHALL never exceed FRAME_W*FRAME_H-1; no address wrap is permitted.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, idx=0 and wait counter=0.
REQ-024 Reset SHALL force all outputs to 0: busy, done, timeout_err, rd_en, rd_addr, gs_rgb, gs_rgb_en, wr_en, wr_addr, wr_data.
REQ-025 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Structure
REQ-026 A shared preprocessing package SHALL hold the state encoding (3-bit), PIX_W=24, GS_W=8 and the default FRAME_W, FRAME_H and TIMEOUT.
REQ-027 The TIMEOUT wait counter SHALL be a sub-module, preproc_timeout_counter, with clear, enable and expired signals. The FSM and idx counter SHALL stay in the top module.

Verification
REQ-028 Scenario 1: 8x4 frame, mock converter with gs=R and L=3 -> exactly 32 wr_en pulses, wr_addr 0..31 in order, wr_data equal to each pixel's R, one done pulse 7 cycles after the last rd_en.
REQ-029 Scenario 2: real rgb2gs, single pixel (122,23,100), 1x1 frame -> wr_data=67, then done.
REQ-030 Scenario 3: gs_valid held low -> timeout_err=1 exactly TIMEOUT cycles after gs_rgb_en rises; busy=0 next cycle; no done.
REQ-031 Scenario 4: abort asserted after the 3rd wr_en -> no further rd_en or wr_en, busy=0 next cycle, done never pulses; a following start rewrites from wr_addr=0.
REQ-032 Scenario 5: start pulsed while busy, and start with abort in IDLE -> both ignored; wr_addr sequence unchanged.
REQ-033 Scenario 6: rst_n pulsed low in CONVERT -> all outputs 0 immediately (asynchronously); no activity until the next start.

Source files
------------

// File: rtl/preproc_frame_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preproc_frame_sequencer_pkg : shared state encoding, widths and frame defaults
// Rev 1.0
// ----------------------------------------------------------------------------
package preproc_frame_sequencer_pkg;

  localparam int PIX_W       = 24;
  localparam int GS_W        = 8;
  localparam int DEF_FRAME_W = 8;
  localparam int DEF_FRAME_H = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_CONVERT = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/preproc_frame_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preproc_frame_sequencer_if : RGB read port, rgb2gs handshake and grayscale write port
// Rev 1.0
// ----------------------------------------------------------------------------
interface preproc_frame_sequencer_if #(
  parameter int ADDR_W = 16
) ();
  import preproc_frame_sequencer_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  gs_rgb;
  logic              gs_rgb_en;
  logic [GS_W-1:0]   gs_in;
  logic              gs_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [GS_W-1:0]   wr_data;

  modport master (
    output rd_en, rd_addr, gs_rgb, gs_rgb_en, wr_en, wr_addr, wr_data,
    input  rd_data, gs_in, gs_valid
  );

  modport slave (
    input  rd_en, rd_addr, gs_rgb, gs_rgb_en, wr_en, wr_addr, wr_data,
    output rd_data, gs_in, gs_valid
  );

endinterface
`default_nettype wire

// File: rtl/preproc_timeout_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preproc_timeout_counter : counts converter wait cycles, flags the last allowed one
// Rev 1.0
// ----------------------------------------------------------------------------
module preproc_timeout_counter
  import preproc_frame_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is reported during the TIMEOUT-th waiting cycle so the FSM leaves on that edge.
  assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/preproc_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// preproc_frame_sequencer : walks a frame pixel by pixel through read, rgb2gs, write
// Rev 1.0
// ----------------------------------------------------------------------------
module preproc_frame_sequencer
  import preproc_frame_sequencer_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic timeout_err,
  preproc_frame_sequencer_if.master bus
);

  localparam int                c_npix     = frame_pixels(FRAME_W, FRAME_H);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(c_npix - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [PIX_W-1:0]  r_gs_rgb;
  logic [GS_W-1:0]   r_wr_data;
  logic              r_timeout_err;
  logic              w_clr_frame;
  logic              w_inc_idx;
  logic              w_ld_rgb;
  logic              w_ld_gs;
  logic              w_set_timeout;
  logic              w_wait_clr;
  logic              w_wait_en;
  logic              w_expired;

  assign w_wait_clr = (r_state == ST_IDLE) || (r_state == ST_LATCH);
  assign w_wait_en  = (r_state == ST_CONVERT) && !bus.gs_valid;

  preproc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wait_clr),
    .enable  (w_wait_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_clr_frame   = 1'b0;
    w_inc_idx     = 1'b0;
    w_ld_rgb      = 1'b0;
    w_ld_gs       = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_next = ST_READ;
          w_clr_frame  = 1'b1;
        end
      end
      ST_READ:  w_state_next = ST_LATCH;
      ST_LATCH: begin
        w_ld_rgb     = 1'b1;
        w_state_next = ST_CONVERT;
      end
      ST_CONVERT: begin
        // A result arriving in the last allowed cycle still wins over expiry.
        if (bus.gs_valid) begin
          w_ld_gs      = 1'b1;
          w_state_next = ST_WRITE;
        end else if (w_expired) begin
          w_set_timeout = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (r_idx == c_last_idx) begin
          w_state_next = ST_DONE;
        end else begin
          w_inc_idx    = 1'b1;
          w_state_next = ST_READ;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_next  = ST_IDLE;
      w_inc_idx     = 1'b0;
      w_ld_gs       = 1'b0;
      w_set_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= '0;
      r_gs_rgb      <= '0;
      r_wr_data     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_clr_frame) begin
        r_idx         <= '0;
        r_timeout_err <= 1'b0;
      end else if (w_inc_idx) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (w_ld_rgb) begin
        r_gs_rgb <= bus.rd_data;
      end
      if (w_ld_gs) begin
        r_wr_data <= bus.gs_in;
      end
    end
  end

  // Strobes decode straight from the state so reset clears them without waiting for a clock.
  assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done          = (r_state == ST_DONE);
  assign timeout_err   = r_timeout_err;
  assign bus.rd_en     = (r_state == ST_READ);
  assign bus.rd_addr   = r_idx;
  assign bus.gs_rgb    = r_gs_rgb;
  assign bus.gs_rgb_en = (r_state == ST_CONVERT);
  assign bus.wr_en     = (r_state == ST_WRITE);
  assign bus.wr_addr   = r_idx;
  assign bus.wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_preproc_frame_sequencer.sv
`default_nettype none
// Randomised scoreboard bench: 8x4 instance with a mock gs=R converter, 1x1 instance with a
// (R+2G+B)/4 converter.
module tb_preproc_frame_sequencer;
  import preproc_frame_sequencer_pkg::*;

  localparam int FW   = 8;
  localparam int FH   = 4;
  localparam int NPIX = FW * FH;
  localparam int AW   = 16;
  localparam int TO   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, busy, done, timeout_err;
  logic start1 = 1'b0, abort1 = 1'b0, busy1, done1, timeout_err1;

  always #5 clk = ~clk;

  preproc_frame_sequencer_if #(.ADDR_W(AW)) bus ();
  preproc_frame_sequencer_if #(.ADDR_W(AW)) bus1 ();

  preproc_frame_sequencer #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .timeout_err(timeout_err), .bus(bus)
  );

  preproc_frame_sequencer #(.FRAME_W(1), .FRAME_H(1), .ADDR_W(AW), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .timeout_err(timeout_err1), .bus(bus1)
  );

  typedef struct { int addr; int data; } wr_t;

  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  wr_t       exp_q[$];
  int        exp_done = 0;
  int        exp1_q[$];
  int        exp1_done = 0;
  int        done_cnt = 0, done1_cnt = 0, wr_cnt = 0;
  int        conv_lat = 3;
  bit        hold_low = 1'b0;
  bit        quiet = 1'b0;
  int        prev_rd = -1, last_rd = -1, en_rise = -1, to_rise = -1;
  logic      prev_en = 1'b0, prev_to = 1'b0;
  int        conv_cnt = 0;
  logic [PIX_W-1:0] rgb_mem [NPIX];
  logic [PIX_W-1:0] px1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endtask

  function automatic logic [7:0] rgb2gs_ref(input logic [23:0] p);
    return 8'((int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RGB buffer and mock converter (gs = R, result L edges after the request rises).
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= rgb_mem[int'(bus.rd_addr) % NPIX];
    if (!bus.gs_rgb_en) begin
      conv_cnt     <= 0;
      bus.gs_valid <= (!busy || bus.rd_en) && ($urandom_range(3) == 0);
      bus.gs_in    <= 8'($urandom);
    end else if (bus.gs_valid) begin
      bus.gs_valid <= 1'b0;
    end else begin
      conv_cnt     <= conv_cnt + 1;
      bus.gs_valid <= !hold_low && (conv_cnt + 1 == conv_lat);
      bus.gs_in    <= bus.gs_rgb[23:16];
    end
  end

  always @(posedge clk) begin
    if (bus1.rd_en) bus1.rd_data <= px1;
    bus1.gs_valid <= bus1.gs_rgb_en && !bus1.gs_valid;
    bus1.gs_in    <= rgb2gs_ref(bus1.gs_rgb);
  end

  // Monitor for the 8x4 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en || bus.wr_en) chk("rd_wr_exclusive", 32'(bus.rd_en & bus.wr_en), 0);
      if (quiet) begin
        chk("quiet_rd_en", 32'(bus.rd_en), 0);
        chk("quiet_wr_en", 32'(bus.wr_en), 0);
      end
      if (bus.rd_en) begin
        if (prev_rd >= 0) chk("rd_interval", 32'(cyc - prev_rd), 32'(4 + conv_lat));
        prev_rd = cyc;
        last_rd = cyc;
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          note_fail("unexpected_wr", int'(bus.wr_addr));
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done == 0) begin
          note_fail("unexpected_done", cyc);
        end else begin
          exp_done--;
          chk("writes_before_done", 32'(exp_q.size()), 0);
          chk("done_latency", 32'(cyc - last_rd), 32'(4 + conv_lat));
        end
      end
      if (bus.gs_rgb_en && !prev_en) en_rise = cyc;
      if (timeout_err && !prev_to) to_rise = cyc;
      prev_en = bus.gs_rgb_en;
      prev_to = timeout_err;
    end else begin
      prev_en = 1'b0;
      prev_to = 1'b0;
    end
  end

  // Monitor for the 1x1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.wr_en) begin
        if (exp1_q.size() == 0) begin
          note_fail("dut1_unexpected_wr", int'(bus1.wr_data));
        end else begin
          chk("dut1_wr_data", 32'(bus1.wr_data), 32'(exp1_q.pop_front()));
          chk("dut1_wr_addr", 32'(bus1.wr_addr), 0);
        end
      end
      if (done1) begin
        done1_cnt++;
        if (exp1_done == 0) note_fail("dut1_unexpected_done", cyc);
        else exp1_done--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_frame(input int lat, input int nexp, input bit exp_dn);
    conv_lat = lat;
    for (int i = 0; i < NPIX; i++) rgb_mem[i] = 24'($urandom);
    for (int i = 0; i < nexp; i++) exp_q.push_back('{addr: i, data: int'(rgb_mem[i][23:16])});
    if (exp_dn) exp_done++;
    prev_rd = -1;
    pulse_start();
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) note_fail({name, "_done_timeout"}, n);
  endtask

  task automatic run_frame(input int lat, input string name);
    int w0;
    w0 = wr_cnt;
    begin_frame(lat, NPIX, 1'b1);
    wait_done(NPIX * (6 + lat) + 20, name);
    tick(2);
    chk({name, "_wr_count"}, 32'(wr_cnt - w0), NPIX);
    chk({name, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_timeout_err"}, 32'(timeout_err), 0);
    chk({name, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({name, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({name, "_gs_rgb"}, 32'(bus.gs_rgb), 0);
    chk({name, "_gs_rgb_en"}, 32'(bus.gs_rgb_en), 0);
    chk({name, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({name, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({name, "_wr_data"}, 32'(bus.wr_data), 0);
  endtask

  initial begin
    int n;
    int seen;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Nominal frame with L=3, then random latencies.
    run_frame(3, "s1_frame");
    for (int k = 0; k < 3; k++) run_frame(int'($urandom_range(5, 1)), "rand_frame");

    // 1x1 instance through the arithmetic converter.
    for (int k = 0; k < 3; k++) begin
      int d0;
      if (k == 0) begin
        px1 = {8'd122, 8'd23, 8'd100};
        exp1_q.push_back(67);
      end else begin
        px1 = 24'($urandom);
        exp1_q.push_back(int'(rgb2gs_ref(px1)));
      end
      exp1_done++;
      d0 = done1_cnt;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (done1_cnt == d0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("dut1_done_seen", 32'(done1_cnt - d0), 1);
      chk("dut1_pending", 32'(exp1_q.size()), 0);
    end

    // Converter never answers.
    hold_low = 1'b1;
    en_rise = -1;
    to_rise = -1;
    begin_frame(3, 0, 1'b0);
    n = 0;
    while (!timeout_err && n < TO + 30) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    chk("timeout_flag", 32'(timeout_err), 1);
    chk("timeout_delay", 32'(to_rise - en_rise), TO);
    chk("timeout_busy", 32'(busy), 0);
    chk("timeout_gs_rgb_en", 32'(bus.gs_rgb_en), 0);
    tick(5);
    chk("timeout_sticky", 32'(timeout_err), 1);
    hold_low = 1'b0;
    begin_frame(2, NPIX, 1'b1);
    chk("timeout_cleared_on_start", 32'(timeout_err), 0);
    wait_done(NPIX * 8 + 20, "after_timeout");
    tick(2);

    // Abort in the cycle of the third write.
    begin_frame(int'($urandom_range(4, 1)), 3, 1'b0);
    n = 0;
    seen = 0;
    while (seen < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.wr_en) seen++;
    end
    if (seen < 3) note_fail("abort_third_wr_missing", seen);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gs_rgb_en", 32'(bus.gs_rgb_en), 0);
    quiet = 1'b1;
    tick(30);
    quiet = 1'b0;
    chk("abort_pending", 32'(exp_q.size()), 0);
    run_frame(3, "after_abort");

    // Start while busy, then start together with abort in idle.
    begin_frame(2, NPIX, 1'b1);
    tick(10);
    pulse_start();
    tick(37);
    pulse_start();
    wait_done(NPIX * 8 + 20, "start_while_busy");
    tick(2);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", 32'(busy), 0);
    quiet = 1'b1;
    tick(20);
    quiet = 1'b0;

    // Reset while waiting on the converter.
    begin_frame(4, 0, 1'b0);
    n = 0;
    while (!bus.gs_rgb_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_in_convert", 32'(bus.gs_rgb_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    tick(20);
    quiet = 1'b0;
    chk("post_reset_busy", 32'(busy), 0);
    run_frame(int'($urandom_range(5, 1)), "after_reset");

    tick(5);
    chk("scoreboard_drained", 32'(exp_q.size() + exp_done + exp1_q.size() + exp1_done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=%0d required=finished", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
